riscv_top: RTL and testbench
============================

# riscv_top

Top level of a single-cycle RV32I-subset processor system: one CPU core (datapath plus controller) with a private word-addressed instruction ROM and data RAM. Every instruction completes in one clock cycle. The data-memory write bus is exported so a bench can watch stores; all other state is internal.

## Interface
- Parameters: none. Memory depths and the program image file name are fixed constants inside the block.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears PC to 0.
- WriteData  output  32  store data, the rs2 register value of the current instruction.
- DataAdr  output  32  ALU result, used as the byte address for lw/sw.
- MemWrite  output  1  high for the whole cycle while the current instruction is sw.

## Operation
- Instruction memory:
  - 64 x 32-bit ROM, initialised at elaboration with $readmemh from "riscvtest.txt".
  - Read combinationally with PC[31:2].
- Data memory:
  - 64 x 32-bit RAM, indexed by DataAdr[31:2]; byte offset ignored, word accesses only.
  - Combinational read.
  - Write of WriteData on the rising clk edge when MemWrite=1.
- Register file:
  - 32 x 32-bit; x0 always reads 0 and writes to it are discarded.
  - Two combinational read ports, one write port written on the rising edge.
- Supported instructions (all others are don't-care; no trap):
  - R-type: add, sub, and, or, slt.
  - I-type ALU: addi, andi, ori, slti.
  - Memory: lw, sw.
  - Control: beq, jal.
- Immediates: sign-extended I, S, B and J formats; B and J immediates have bit 0 = 0.
- ALU:
  - Operations: add, sub, and, or, slt (signed compare via sign of A-B with overflow correction).
  - Zero flag drives the beq decision.
  - Arithmetic wraps modulo 2^32.
- Next PC:
  - PC+imm when (beq and Zero) or jal; PC+4 otherwise.
  - No alignment checks.
- Writeback source:
  - ALU result for R-type and I-type ALU instructions.
  - Memory read data for lw.
  - PC+4 for jal.
  - No register write for sw or beq.
- Outputs are purely combinational functions of PC, the register file and the ROM.

## Timing
- Single-cycle design with no pipeline, stalls or handshake.
- One instruction retires per rising edge after reset is released.
- Reset:
  - PC=0 immediately, asynchronously.
  - Outputs then reflect the instruction at address 0 (addi, so MemWrite=0).
  - The register file and data RAM are not cleared; their power-up contents are X.
- Reset asserted mid-program: PC returns to 0 asynchronously; register and RAM contents are retained.
- Same-cycle register write and read of the same register: the read returns the old value (write takes effect at the edge).
- A store and a load to the same word in the same cycle cannot occur (one memory operation per instruction).

## Test plan
- Reset behaviour: hold reset high for 22 ns with a 10 ns clock -> PC=0 and MemWrite=0 throughout.
- Full reference program, riscvtest.txt run from reset:
  - Program: addi/or/and/add/beq/slt/sub/sw/lw/jal sequence.
  - Required stores: first MemWrite with DataAdr=96, WriteData=7; then DataAdr=100, WriteData=25.
  - No other store address may ever appear.
- Branch coverage, both directions:
  - beq x5,x7 with 11 vs 3 must fall through.
  - beq x4,x0 with x4=0 must be taken, skipping "addi x5,x0,0", so x5 stays 11.
- jal: jal x3 at PC 0x40 -> x3=0x44 and PC=0x48, skipping "addi x2,x0,1" at 0x44; the final store uses x3 base, 0x44+0x20=100.
- Load/store round trip: sw 7 to address 96, then lw x2,96(x0) -> x2=7 the following cycle; x9=7+11=18.
- Final loop: "beq x2,x2,done" holds PC constant.
  - MemWrite stays 0 for at least 10 further cycles.
  - A reset pulse mid-loop restarts the program, and the 96/100 stores recur.

Source files
------------

// File: rtl/riscv_top.sv
// Single-cycle RV32I-subset processor: core, instruction ROM and data RAM.
// Executes add/sub/and/or/slt, addi/andi/ori/slti, lw/sw, beq and jal.
module riscv_top (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic        MemWrite
);

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_t;
  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} res_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [31:0] pc, pc_next, pc_plus4, pc_target;
  logic [31:0] instr, imm_ext, rd1, rd2, src_b;
  logic [31:0] alu_result, diff, read_data, result;
  logic        reg_write, alu_src, branch, jump, zero, overflow;
  imm_t        imm_src;
  res_t        result_src;
  alu_t        alu_ctrl;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  logic [31:0] rf  [0:31];
  logic [31:0] ram [0:63];

  // Program image of riscvtest.txt, held as a constant table so the ROM needs no init process
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'd0:    rom_word = 32'h00500113;
      6'd1:    rom_word = 32'h00C00193;
      6'd2:    rom_word = 32'hFF718393;
      6'd3:    rom_word = 32'h0023E233;
      6'd4:    rom_word = 32'h0041F2B3;
      6'd5:    rom_word = 32'h004282B3;
      6'd6:    rom_word = 32'h02728863;
      6'd7:    rom_word = 32'h0041A233;
      6'd8:    rom_word = 32'h00020463;
      6'd9:    rom_word = 32'h00000293;
      6'd10:   rom_word = 32'h0023A233;
      6'd11:   rom_word = 32'h005203B3;
      6'd12:   rom_word = 32'h402383B3;
      6'd13:   rom_word = 32'h0471AA23;
      6'd14:   rom_word = 32'h06002103;
      6'd15:   rom_word = 32'h005104B3;
      6'd16:   rom_word = 32'h008001EF;
      6'd17:   rom_word = 32'h00100113;
      6'd18:   rom_word = 32'h00910133;
      6'd19:   rom_word = 32'h0221A023;
      6'd20:   rom_word = 32'h00210063;
      default: rom_word = 32'h00000000;
    endcase
  endfunction

  assign instr  = rom_word(pc[7:2]);
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    MemWrite   = 1'b0;
    result_src = RES_ALU;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_ctrl   = ALU_ADD;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OP_SW: begin
        imm_src  = IMM_S;
        alu_src  = 1'b1;
        MemWrite = 1'b1;
      end
      OP_R, OP_I: begin
        reg_write = 1'b1;
        alu_src   = (opcode == OP_I);
        case (funct3)
          // instr[30] selects sub only for register-register ops; addi has no funct7
          3'b000:  alu_ctrl = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      OP_BEQ: begin
        imm_src  = IMM_B;
        branch   = 1'b1;
        alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = IMM_J;
        jump       = 1'b1;
        result_src = RES_PC4;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (imm_src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  end

  assign rd1   = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rd2   = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign src_b = alu_src ? imm_ext : rd2;

  assign diff     = rd1 - src_b;
  assign overflow = (rd1[31] ^ src_b[31]) & (diff[31] ^ rd1[31]);

  always_comb begin
    case (alu_ctrl)
      ALU_SUB: alu_result = diff;
      ALU_AND: alu_result = rd1 & src_b;
      ALU_OR:  alu_result = rd1 | src_b;
      ALU_SLT: alu_result = {31'd0, diff[31] ^ overflow};
      default: alu_result = rd1 + src_b;
    endcase
  end

  assign zero      = (alu_result == 32'd0);
  assign read_data = ram[alu_result[7:2]];

  always_comb begin
    case (result_src)
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      default: result = alu_result;
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm_ext;
  assign pc_next   = ((branch && zero) || jump) ? pc_target : pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= 32'd0;
    else       pc <= pc_next;
  end

  // Register file and RAM are deliberately not reset; they survive a mid-program reset
  always_ff @(posedge clk) begin
    if (reg_write && rd != 5'd0) rf[rd] <= result;
  end

  always_ff @(posedge clk) begin
    if (MemWrite) ram[alu_result[7:2]] <= rd2;
  end

  assign WriteData = rd2;
  assign DataAdr   = alu_result;

endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: runs the reference program, scoreboards every store,
// and checks the PC trace and key register values against hand-computed values.
module tb_riscv_top;

  logic        clk;
  logic        reset;
  logic [31:0] WriteData;
  logic [31:0] DataAdr;
  logic        MemWrite;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } store_t;

  store_t exp_q[$];

  riscv_top dut (
    .clk      (clk),
    .reset    (reset),
    .WriteData(WriteData),
    .DataAdr  (DataAdr),
    .MemWrite (MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NTRACE = 19;
  logic [31:0] exp_pc [NTRACE] = '{
    32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
    32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h48, 32'h4C,
    32'h50
  };

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Store monitor: any cycle with MemWrite set must match the next queued store
  always @(negedge clk) begin
    if (MemWrite !== 1'b0) begin
      store_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_store: MemWrite=%b adr=0x%08h data=0x%08h, none expected at %0t",
                 MemWrite, DataAdr, WriteData, $time);
      end else begin
        e = exp_q.pop_front();
        if (DataAdr !== e.adr || WriteData !== e.data) begin
          errors++;
          $display("FAIL store: got adr=0x%08h data=0x%08h expected adr=0x%08h data=0x%08h at %0t",
                   DataAdr, WriteData, e.adr, e.data, $time);
        end
      end
    end
  end

  task automatic push_program_stores();
    exp_q.push_back('{adr: 32'd96,  data: 32'd7});
    exp_q.push_back('{adr: 32'd100, data: 32'd25});
  endtask

  // Called just after reset release, PC still 0; steps through the whole program
  task automatic run_program(input string tag);
    check32({tag, "_pc0"}, dut.pc, exp_pc[0]);
    for (int k = 1; k < NTRACE; k++) begin
      @(posedge clk); #1;
      check32($sformatf("%s_pc_step%0d", tag, k), dut.pc, exp_pc[k]);
      if (exp_pc[k] == 32'h3C) check32({tag, "_lw_x2"}, dut.rf[2], 32'd7);
      if (exp_pc[k] == 32'h40) check32({tag, "_x9"}, dut.rf[9], 32'd18);
      if (exp_pc[k] == 32'h48) begin
        check32({tag, "_jal_x3"}, dut.rf[3], 32'h44);
        check32({tag, "_x5_kept"}, dut.rf[5], 32'd11);
        check32({tag, "_x2_not_1"}, dut.rf[2], 32'd7);
      end
      if (exp_pc[k] == 32'h50) check32({tag, "_final_x2"}, dut.rf[2], 32'd25);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check32($sformatf("%s_loop_pc%0d", tag, k), dut.pc, 32'h50);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_stores: %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      check32($sformatf("reset_pc%0d", k), dut.pc, 32'h0);
      check32($sformatf("reset_memwrite%0d", k), {31'd0, MemWrite}, 32'd0);
      #7;
    end
    push_program_stores();
    #(22 - 23 + 1);
    reset = 1'b0;
    #1;
    run_program("run1");

    // Mid-loop asynchronous reset: PC must drop immediately, no clock edge needed
    #3;
    push_program_stores();
    reset = 1'b1;
    #1;
    check32("async_reset_pc", dut.pc, 32'h0);
    @(posedge clk); #1;
    check32("held_reset_pc", dut.pc, 32'h0);
    check32("held_reset_memwrite", {31'd0, MemWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    run_program("run2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
